// File: rtl/cpu16_pkg.sv
`default_nettype none
// ============================================================================
//  Package : cpu16_pkg
//  Shared widths, opcodes and MainControl bit positions for the 16-bit CPU.
//  Revision: 1.0
// ============================================================================
package cpu16_pkg;

    localparam int WORD_W     = 16;
    localparam int REG_ADDR_W = 2;

    // Opcode field ir[15:12]
    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;

    // MainControl bit-field positions
    localparam int CTRL_REGDST   = 0;
    localparam int CTRL_ALUSRC   = 1;
    localparam int CTRL_MEMTOREG = 2;
    localparam int CTRL_REGWRITE = 3;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_BRANCH   = 5;
    localparam int CTRL_W        = 6;

endpackage
`default_nettype wire

// File: rtl/data_mem.sv
`default_nettype none
// ============================================================================
//  Module  : data_mem
//  Word-addressed data memory: negedge synchronous write, combinational read.
//  Revision: 1.0
// ============================================================================
module data_mem
    import cpu16_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    always_ff @(negedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module  : mem_wb_stage
//  MEM stage plus MEM/WB register; optional wait states via MEM_WAIT_STATE_EN.
//  Revision: 1.0
// ============================================================================
module mem_wb_stage
    import cpu16_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic [WORD_W-1:0]     ex_ir,
    input  logic [WORD_W-1:0]     ex_alu_out,
    input  logic [WORD_W-1:0]     ex_rd2,
    input  logic [REG_ADDR_W-1:0] ex_wr,
    input  logic                  ex_regwrite,
    input  logic                  ex_memtoreg,
    input  logic                  ex_memwrite,
    output logic                  stall,
    output logic                  wb_valid,
    output logic [WORD_W-1:0]     wb_ir,
    output logic [REG_ADDR_W-1:0] wb_wr,
    output logic [WORD_W-1:0]     wb_wd,
    output logic                  wb_regwrite,
    output logic                  mem_fault
);

    logic [ADDR_W-1:0] w_idx;
    logic [WORD_W-1:0] w_rdata;
    logic              w_is_mem;
    logic              w_is_sw;
    logic              w_is_lw;
    logic              w_stall;
    logic              w_go;
    logic              w_mem_we;
    logic              w_unused_addr;

    // Byte address to word index; upper bits drop so addresses wrap
    assign w_idx         = ex_alu_out[ADDR_W:1];
    assign w_unused_addr = ^ex_alu_out[WORD_W-1:ADDR_W+1];

    assign w_is_mem = ex_valid & (ex_memtoreg | ex_memwrite);
    assign w_is_sw  = ex_valid & ex_memwrite;
    assign w_is_lw  = ex_valid & ex_memtoreg & ~ex_memwrite;

`ifdef MEM_WAIT_STATE_EN
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    localparam logic       c_has_wait  = (WAIT_CYCLES != 0);
    localparam logic [3:0] c_cnt_init  = 4'(WAIT_CYCLES - 1);

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;

    always_ff @(negedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_is_mem && c_has_wait) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = c_cnt_init;
                end
            end
            S_WAIT: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_stall = 1'b0;
        if (r_state == S_IDLE) begin
            w_stall = w_is_mem & c_has_wait;
        end else if (r_state == S_WAIT) begin
            w_stall = (r_cnt != 4'd0);
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (WAIT_CYCLES != 0);
    assign w_stall      = 1'b0;
`endif

    assign stall = w_stall;
    assign w_go  = ~w_stall;
    // Reset on the completing edge aborts the store
    assign w_mem_we = w_is_sw & w_go & ~reset;

    data_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_data_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (w_idx),
        .i_wdata (ex_rd2),
        .o_rdata (w_rdata)
    );

    always_ff @(negedge clk) begin
        if (reset) begin
            wb_valid    <= 1'b0;
            wb_ir       <= '0;
            wb_wr       <= '0;
            wb_wd       <= '0;
            wb_regwrite <= 1'b0;
            mem_fault   <= 1'b0;
        end else if (w_go) begin
            wb_valid    <= ex_valid;
            wb_ir       <= ex_ir;
            wb_wr       <= ex_wr;
            wb_wd       <= w_is_lw ? w_rdata : ex_alu_out;
            wb_regwrite <= ex_valid & ex_regwrite & (ex_wr != '0) & ~ex_memwrite;
            if (w_is_mem && ex_alu_out[0]) begin
                mem_fault <= 1'b1;
            end
        end else begin
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
        end
    end

endmodule
`default_nettype wire
